conv3x3_engine: RTL and testbench

//  Downstream consumer of three row line buffers (rows r, r+1, r+2 of the feature map).
//  Per output column it reads 3 pixels from each buffer, forms a 3x3 window and computes
//  one signed MAC of the window with a loadable 3x3 kernel plus bias.
//  One start pulse processes one output row: IMG_W-2 results, then returns to IDLE.

---
 rtl/conv3x3_engine.sv | 165 ++++++++++++++++
 tb/tb_conv3x3_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_engine.sv
// conv3x3_engine: 3x3 signed MAC over three line-buffer rows, one output row per start pulse.
// Optional feature macro: RELU_EN (clamp negative results to zero).
`default_nettype none

module conv3x3_engine #(
  parameter int IMG_W = 28,
  parameter int PIX_W = 8,
  parameter int W_W   = 8,
  parameter int B_W   = 16,
  parameter int ACC_W = 22
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 w_wr_en_i,
  input  logic [3:0]           w_idx_i,
  input  logic [W_W-1:0]       w_data_i,
  input  logic                 bias_wr_en_i,
  input  logic [B_W-1:0]       bias_data_i,
  output logic                 lb_rd_en_o,
  output logic [6:0]           lb_rd_addr_o,
  input  logic [3*PIX_W-1:0]   lb0_data_i,
  input  logic [3*PIX_W-1:0]   lb1_data_i,
  input  logic [3*PIX_W-1:0]   lb2_data_i,
  input  logic [2:0]           lb_valid_i,
  output logic [ACC_W-1:0]     conv_out_o,
  output logic                 conv_valid_o,
  output logic [6:0]           conv_col_o,
  output logic                 busy_o,
  output logic                 row_done_o
);

  localparam int         PROD_W   = PIX_W + W_W + 1;
  localparam logic [6:0] LAST_COL = 7'(IMG_W - 3);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_GAP  = 3'd2,
    S_CAPT = 3'd3,
    S_CALC = 3'd4
  } state_t;

  state_t             state_q;
  logic [6:0]         col_q;
  logic               rd_en_q;
  logic               busy_q;
  logic               conv_valid_q;
  logic               row_done_q;
  logic [6:0]         conv_col_q;
  logic [ACC_W-1:0]   conv_out_q;
  logic [W_W-1:0]     w_q   [9];
  logic [B_W-1:0]     bias_q;
  logic [PIX_W-1:0]   px_q  [9];

  logic [3*PIX_W-1:0]       lb_row [3];
  logic signed [PROD_W-1:0] px_ext [9];
  logic signed [PROD_W-1:0] w_ext  [9];
  logic signed [PROD_W-1:0] prod_d [9];
  logic [ACC_W-1:0]         sum_d;
  logic [ACC_W-1:0]         mac_d;

  assign lb_row[0] = lb0_data_i;
  assign lb_row[1] = lb1_data_i;
  assign lb_row[2] = lb2_data_i;

  // Pixels are unsigned, so they get a zero sign bit before the signed multiply.
  always_comb begin
    sum_d = {{(ACC_W-B_W){bias_q[B_W-1]}}, bias_q};
    for (int i = 0; i < 9; i++) begin
      px_ext[i] = $signed({{(W_W){1'b0}}, px_q[i]});
      w_ext[i]  = $signed({{(PIX_W+1){w_q[i][W_W-1]}}, w_q[i]});
      prod_d[i] = px_ext[i] * w_ext[i];
      sum_d     = sum_d + {{(ACC_W-PROD_W){prod_d[i][PROD_W-1]}}, prod_d[i]};
    end
`ifdef RELU_EN
    mac_d = sum_d[ACC_W-1] ? '0 : sum_d;
`else
    mac_d = sum_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      conv_valid_q <= 1'b0;
      row_done_q   <= 1'b0;
      conv_col_q   <= '0;
      conv_out_q   <= '0;
      bias_q       <= '0;
      for (int i = 0; i < 9; i++) begin
        w_q[i]  <= '0;
        px_q[i] <= '0;
      end
    end else begin
      conv_valid_q <= 1'b0;
      row_done_q   <= 1'b0;

      // Kernel is frozen while a row is in flight; the start cycle still counts as idle.
      if (state_q == S_IDLE) begin
        if (w_wr_en_i && (w_idx_i < 4'd9)) w_q[w_idx_i] <= w_data_i;
        if (bias_wr_en_i) bias_q <= bias_data_i;
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_REQ;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_REQ: begin
          rd_en_q <= 1'b0;
          state_q <= S_GAP;
        end
        S_GAP: state_q <= S_CAPT;
        S_CAPT: begin
          if (lb_valid_i == 3'b111) begin
            for (int r = 0; r < 3; r++) begin
              for (int c = 0; c < 3; c++) begin
                px_q[3*r+c] <= lb_row[r][c*PIX_W +: PIX_W];
              end
            end
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          conv_out_q   <= mac_d;
          conv_valid_q <= 1'b1;
          conv_col_q   <= col_q;
          if (col_q == LAST_COL) begin
            row_done_q <= 1'b1;
            col_q      <= '0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            col_q   <= col_q + 7'd1;
            rd_en_q <= 1'b1;
            state_q <= S_REQ;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign lb_rd_en_o   = rd_en_q;
  assign lb_rd_addr_o = col_q;
  assign conv_out_o   = conv_out_q;
  assign conv_valid_o = conv_valid_q;
  assign conv_col_o   = conv_col_q;
  assign busy_o       = busy_q;
  assign row_done_o   = row_done_q;

endmodule

`default_nettype wire

// File: tb/tb_conv3x3_engine.sv
// Bench for conv3x3_engine: line-buffer model with random latency, window-sum reference per column.
`default_nettype none

module tb_conv3x3_engine;
  localparam int IMG_W = 28;
  localparam int NCOL  = IMG_W - 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        w_wr_en = 1'b0;
  logic [3:0]  w_idx = '0;
  logic [7:0]  w_data = '0;
  logic        bias_wr_en = 1'b0;
  logic [15:0] bias_data = '0;
  logic [23:0] lb0 = '0, lb1 = '0, lb2 = '0;
  logic [2:0]  lb_valid_raw = 3'b111;
  logic [2:0]  hold_mask = 3'b000;
  wire  [2:0]  lb_valid = lb_valid_raw & ~hold_mask;
  wire         lb_rd_en;
  wire  [6:0]  lb_rd_addr;
  wire  [21:0] conv_out;
  wire         conv_valid;
  wire  [6:0]  conv_col;
  wire         busy;
  wire         row_done;

  conv3x3_engine dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .w_wr_en_i(w_wr_en), .w_idx_i(w_idx), .w_data_i(w_data),
    .bias_wr_en_i(bias_wr_en), .bias_data_i(bias_data),
    .lb_rd_en_o(lb_rd_en), .lb_rd_addr_o(lb_rd_addr),
    .lb0_data_i(lb0), .lb1_data_i(lb1), .lb2_data_i(lb2), .lb_valid_i(lb_valid),
    .conv_out_o(conv_out), .conv_valid_o(conv_valid), .conv_col_o(conv_col),
    .busy_o(busy), .row_done_o(row_done)
  );

  always #5 clk = ~clk;

  // Reference state: image rows, kernel and bias as plain integers.
  int img [3][IMG_W];
  int kw  [9];
  int kb;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint expect_at(input int c);
    longint s = kb;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        s += longint'(kw[3*r+k]) * longint'(img[r][c+k]);
`ifdef RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  function automatic logic [23:0] pack_row(input int r, input int a);
    logic [23:0] v = '0;
    for (int k = 0; k < 3; k++)
      if (a + k < IMG_W) v[8*k +: 8] = 8'(img[r][a+k]);
    return v;
  endfunction

  // Line buffers: drop valid on an accepted read, return data after 1..4 cycles.
  int lat_cnt = 0;
  int rd_a = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      lat_cnt = 0;
      lb_valid_raw = 3'b111;
    end else if (lb_rd_en) begin
      rd_a = int'(lb_rd_addr);
      lat_cnt = 1 + int'($urandom_range(0, 3));
      lb_valid_raw = 3'b000;
    end else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        lb0 = pack_row(0, rd_a);
        lb1 = pack_row(1, rd_a);
        lb2 = pack_row(2, rd_a);
        lb_valid_raw = 3'b111;
      end
    end
  end

  logic signed [63:0] got_out [$];
  int                 got_col [$];
  bit                 got_done[$];
  int                 stray_done = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (conv_valid) begin
        got_out.push_back($signed(conv_out));
        got_col.push_back(int'(conv_col));
        got_done.push_back(row_done);
      end else if (row_done) begin
        stray_done++;
      end
    end
  end

  task automatic clear_mon();
    got_out.delete(); got_col.delete(); got_done.delete(); stray_done = 0;
  endtask

  task automatic wr_w(input int idx, input int val);
    @(negedge clk); w_wr_en = 1'b1; w_idx = 4'(idx); w_data = 8'(val);
    @(negedge clk); w_wr_en = 1'b0;
    if (idx < 9) kw[idx] = val;
  endtask

  task automatic load_kernel(input int wv [9], input int bv);
    for (int i = 0; i < 9; i++) wr_w(i, wv[i]);
    wr_w(9 + int'($urandom_range(0, 6)), int'($urandom_range(0, 255)));
    @(negedge clk); bias_wr_en = 1'b1; bias_data = 16'(bv);
    @(negedge clk); bias_wr_en = 1'b0;
    kb = bv;
  endtask

  task automatic rand_image();
    for (int r = 0; r < 3; r++)
      for (int a = 0; a < IMG_W; a++) img[r][a] = int'($urandom_range(0, 255));
  endtask

  task automatic rand_kernel();
    int wv [9];
    for (int i = 0; i < 9; i++) wv[i] = int'($urandom_range(0, 255)) - 128;
    load_kernel(wv, int'($urandom_range(0, 65535)) - 32768);
  endtask

  task automatic run_row(input string name, input int hold_col, input bit busy_wr,
                         input bit sw_en, input int sw_idx, input int sw_val);
    int  cycles = 0;
    bit  done = 0;
    bit  held = 0;
    int  bad;
    int  n;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    if (sw_en) begin w_wr_en = 1'b1; w_idx = 4'(sw_idx); w_data = 8'(sw_val); kw[sw_idx] = sw_val; end
    @(negedge clk);
    start = 1'b0; w_wr_en = 1'b0;
    while (!done && cycles < 1000) begin
      @(negedge clk); cycles++;
      if (busy_wr && cycles == 30) begin
        check({name, "_busy_mid"}, busy, 1);
        w_wr_en = 1'b1; w_idx = 4'd4; w_data = 8'd7;
      end else if (busy_wr) begin
        w_wr_en = 1'b0;
      end
      if (hold_col >= 0 && !held && lb_rd_en && int'(lb_rd_addr) == hold_col) begin
        held = 1; hold_mask = 3'b010; bad = 0;
        repeat (10) begin
          @(negedge clk); cycles++;
          if (conv_valid || lb_rd_en) bad++;
        end
        hold_mask = 3'b000;
        check({name, "_hold_stall"}, bad, 0);
      end
      if (got_done.size() > 0 && got_done[got_done.size()-1]) done = 1;
    end
    w_wr_en = 1'b0;
    check({name, "_finished"}, done, 1);
    @(negedge clk);
    check({name, "_busy_after"}, busy, 0);
    n = got_out.size();
    check({name, "_count"}, n, NCOL);
    if (n > NCOL) n = NCOL;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_col[%0d]", name, i), got_col[i], i);
      check($sformatf("%s_out[%0d]", name, i), got_out[i], expect_at(i));
      check($sformatf("%s_done[%0d]", name, i), got_done[i], (i == NCOL-1));
    end
    check({name, "_stray_done"}, stray_done, 0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_rd_en"},    lb_rd_en, 0);
    check({name, "_rd_addr"},  lb_rd_addr, 0);
    check({name, "_conv_out"}, conv_out, 0);
    check({name, "_valid"},    conv_valid, 0);
    check({name, "_col"},      conv_col, 0);
    check({name, "_busy"},     busy, 0);
    check({name, "_row_done"}, row_done, 0);
  endtask

  initial begin
    int wv [9];
    int guard;
    for (int i = 0; i < 9; i++) kw[i] = 0;
    kb = 0;
    for (int r = 0; r < 3; r++) for (int a = 0; a < IMG_W; a++) img[r][a] = 0;

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All-ones kernel on a flat image of 10s.
    for (int i = 0; i < 9; i++) wv[i] = 1;
    for (int r = 0; r < 3; r++) for (int a = 0; a < IMG_W; a++) img[r][a] = 10;
    load_kernel(wv, 0);
    run_row("ones", -1, 0, 0, 0, 0);
    if (got_out.size() > 0) check("ones_lit", got_out[0], 90);

    // Centre tap only, middle row carries its own address.
    for (int i = 0; i < 9; i++) wv[i] = (i == 4) ? 1 : 0;
    rand_image();
    for (int a = 0; a < IMG_W; a++) img[1][a] = a;
    load_kernel(wv, 0);
    run_row("centre", -1, 0, 0, 0, 0);
    if (got_out.size() > 5) check("centre_lit5", got_out[5], 6);

    // Most negative corner.
    for (int i = 0; i < 9; i++) wv[i] = -128;
    for (int r = 0; r < 3; r++) for (int a = 0; a < IMG_W; a++) img[r][a] = 255;
    load_kernel(wv, -5);
    run_row("negmax", -1, 0, 0, 0, 0);
`ifdef RELU_EN
    if (got_out.size() > 0) check("negmax_lit", got_out[0], 0);
`else
    if (got_out.size() > 0) check("negmax_lit", got_out[0], -293765);
`endif

    // Random row with a stalled buffer and a dropped mid-row weight write.
    rand_image(); rand_kernel();
    run_row("stall", 7, 1, 0, 0, 0);

    // Same write while idle now lands; plus a write riding on the start cycle.
    rand_image();
    wr_w(4, 7);
    run_row("idlewr", -1, 0, 1, 0, int'($urandom_range(0, 255)) - 128);

    for (int k = 0; k < 2; k++) begin
      rand_image(); rand_kernel();
      run_row($sformatf("rand%0d", k), -1, 0, 0, 0, 0);
    end

    // Asynchronous reset while column 5 is in flight.
    rand_image(); rand_kernel();
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (!(lb_rd_en && lb_rd_addr == 7'd5) && guard < 500) begin
      @(negedge clk); guard++;
    end
    check("midrst_reach_col5", guard < 500, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midrst");
    for (int i = 0; i < 9; i++) kw[i] = 0;
    kb = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_row("cleared", -1, 0, 0, 0, 0);
    rand_image(); rand_kernel();
    run_row("reload", -1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
